// File: rtl/glitchless_clk_div_pkg.sv
// glitchless_clk_div_pkg: shared FSM state type and default ratio width for the clock divider
package glitchless_clk_div_pkg;
  localparam int RATIO_W = 4;
  typedef enum logic [1:0] {STOP, HIGH, LOW} clkdiv_state_e;
endpackage

// File: rtl/glitchless_clk_div_if.sv
// glitchless_clk_div_if: control and divided-clock signals of the clock divider
interface glitchless_clk_div_if #(parameter int RATIO_W = glitchless_clk_div_pkg::RATIO_W);
  logic en;
  logic cfg_req;
  logic [RATIO_W-1:0] cfg_ratio;
  logic cfg_ack;
  logic outclk;
  logic outclk_rise;
  logic running;
  modport master (output en, cfg_req, cfg_ratio, input cfg_ack, outclk, outclk_rise, running);
  modport slave (input en, cfg_req, cfg_ratio, output cfg_ack, outclk, outclk_rise, running);
endinterface

// File: rtl/glitchless_clk_div.sv
// glitchless_clk_div: programmable 50% duty clock divider that only changes ratio or stops at period boundaries
module glitchless_clk_div
  import glitchless_clk_div_pkg::*;
#(
  parameter int RATIO_W = glitchless_clk_div_pkg::RATIO_W,
  parameter logic [RATIO_W-1:0] RST_RATIO = '0
) (
  input logic clk,
  input logic rst,
  glitchless_clk_div_if.slave bus
);
  clkdiv_state_e state_q, state_d;
  logic [RATIO_W-1:0] cnt_q, cnt_d, ratio_q, ratio_d, pend_r_q, pend_r_d, eff_r;
  logic pend_v_q, pend_v_d, eff_v, boundary;
  logic outclk_q, outclk_d, rise_q, rise_d, ack_q, ack_d;
  // State, phase counter, active/pending ratio and registered outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= STOP;
      cnt_q <= '0;
      ratio_q <= RST_RATIO;
      pend_r_q <= '0;
      pend_v_q <= 1'b0;
      outclk_q <= 1'b0;
      rise_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ratio_q <= ratio_d;
      pend_r_q <= pend_r_d;
      pend_v_q <= pend_v_d;
      outclk_q <= outclk_d;
      rise_q <= rise_d;
      ack_q <= ack_d;
    end
  // Next state: a same-edge cfg_req beats the stored pending ratio; STOP behaves as a permanent boundary
  always_comb begin
    eff_v = pend_v_q | bus.cfg_req;
    eff_r = bus.cfg_req ? bus.cfg_ratio : pend_r_q;
    boundary = cnt_q == ratio_q;
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    ratio_d = ratio_q;
    pend_v_d = eff_v;
    pend_r_d = eff_r;
    outclk_d = outclk_q;
    rise_d = 1'b0;
    ack_d = 1'b0;
    if (state_q == HIGH) begin
      if (boundary) begin
        state_d = LOW;
        outclk_d = 1'b0;
        cnt_d = '0;
      end
    end else if (state_q != LOW || boundary) begin
      ratio_d = eff_v ? eff_r : ratio_q;
      pend_v_d = 1'b0;
      ack_d = eff_v;
      state_d = bus.en ? HIGH : STOP;
      outclk_d = bus.en;
      rise_d = bus.en;
      cnt_d = '0;
    end
  end
  // Outputs come straight from flops except running, a decode of the state register
  always_comb begin
    bus.outclk = outclk_q;
    bus.outclk_rise = rise_q;
    bus.cfg_ack = ack_q;
    bus.running = state_q != STOP;
  end
endmodule

// File: tb/tb_glitchless_clk_div.sv
`timescale 1ns/1ps
// tb_glitchless_clk_div: directed per-cycle vectors and reset sequences for glitchless_clk_div
module tb_glitchless_clk_div;
  typedef struct {
    logic en;
    logic req;
    logic [3:0] r;
    logic [3:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int passed = 0;
  vec_t vecs[$];
  glitchless_clk_div_if #(.RATIO_W(4)) bus ();
  glitchless_clk_div #(.RATIO_W(4), .RST_RATIO(4'd0)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #0.5 clk = ~clk;
  function automatic logic [3:0] outs();
    return {bus.outclk, bus.outclk_rise, bus.cfg_ack, bus.running};
  endfunction
  task automatic check(input string nm, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got {outclk,rise,ack,running}=%b, expected %b", nm, got, exp);
  endtask
  task automatic step(input logic e, input logic q, input logic [3:0] r, input logic [3:0] exp, input string nm);
    bus.en = e;
    bus.cfg_req = q;
    bus.cfg_ratio = r;
    @(posedge clk);
    @(negedge clk);
    check(nm, outs(), exp);
  endtask
  task automatic add(input logic e, input logic q, input logic [3:0] r, input logic [3:0] exp);
    vecs.push_back('{e, q, r, exp});
  endtask
  initial begin
    bus.en = 1'b0;
    bus.cfg_req = 1'b0;
    bus.cfg_ratio = 4'd0;
    // expected bits are {outclk, outclk_rise, cfg_ack, running}
    // R=0 start and free-run
    add(1,0,0,4'b1101); add(1,0,0,4'b0001); add(1,0,0,4'b1101); add(1,0,0,4'b0001); add(1,0,0,4'b1101);
    // cfg_req R=3 at the end of a HIGH phase, applied at the boundary
    add(1,1,3,4'b0001); add(1,0,0,4'b1111);
    add(1,0,0,4'b1001); add(1,0,0,4'b1001); add(1,0,0,4'b1001); add(1,0,0,4'b0001);
    add(1,0,0,4'b0001); add(1,0,0,4'b0001); add(1,0,0,4'b0001); add(1,0,0,4'b1101);
    // two requests 5 then 1 in one period: last wins, single ack
    add(1,1,5,4'b1001); add(1,1,1,4'b1001); add(1,0,0,4'b1001); add(1,0,0,4'b0001);
    add(1,0,0,4'b0001); add(1,0,0,4'b0001); add(1,0,0,4'b0001); add(1,0,0,4'b1111);
    add(1,0,0,4'b1001); add(1,0,0,4'b0001); add(1,0,0,4'b0001); add(1,0,0,4'b1101);
    // back to R=3
    add(1,1,3,4'b1001); add(1,0,0,4'b0001); add(1,0,0,4'b0001); add(1,0,0,4'b1111);
    // en dropped two cycles into HIGH: period completes, then STOP
    add(1,0,0,4'b1001); add(0,0,0,4'b1001); add(0,0,0,4'b1001); add(0,0,0,4'b0001);
    add(0,0,0,4'b0001); add(0,0,0,4'b0001); add(0,0,0,4'b0001); add(0,0,0,4'b0000);
    add(0,0,0,4'b0000); add(1,0,0,4'b1101);
    add(0,0,0,4'b1001); add(0,0,0,4'b1001); add(0,0,0,4'b1001); add(0,0,0,4'b0001);
    add(0,0,0,4'b0001); add(0,0,0,4'b0001); add(0,0,0,4'b0001); add(0,0,0,4'b0000);
    // cfg_req R=2 while stopped: ack without starting, then 6-cycle period
    add(0,1,2,4'b0010); add(0,0,0,4'b0000); add(1,0,0,4'b1101);
    add(1,0,0,4'b1001); add(1,0,0,4'b1001); add(1,0,0,4'b0001);
    add(1,0,0,4'b0001); add(1,0,0,4'b0001); add(1,0,0,4'b1101);
    repeat (20) @(negedge clk);
    check("reset_state", outs(), 4'b0000);
    rst = 1'b0;
    foreach (vecs[i]) step(vecs[i].en, vecs[i].req, vecs[i].r, vecs[i].exp, $sformatf("vec%0d", i));
    // async reset while HIGH with a pending ratio 7
    bus.cfg_req = 1'b1;
    bus.cfg_ratio = 4'd7;
    @(posedge clk);
    #0.2;
    check("pre_rst_high", outs(), 4'b1001);
    rst = 1'b1;
    #0.1;
    check("async_rst", outs(), 4'b0000);
    bus.cfg_req = 1'b0;
    bus.en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1,0,0,4'b1101,"post_rst_rise");
    step(1,0,0,4'b0001,"post_rst_r0_low");
    step(1,0,0,4'b1101,"post_rst_no_ack");
    // en and cfg_req together in STOP: new ratio governs the first HIGH
    step(0,0,0,4'b0001,"stop2_low");
    step(0,0,0,4'b0000,"stop2_park");
    step(1,1,1,4'b1111,"start_with_cfg");
    step(1,0,0,4'b1001,"start_cfg_high2");
    step(1,0,0,4'b0001,"start_cfg_low");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
